// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU command/response protocol: function ids,
// issuer state encoding and the datapath width.
package cfu_pkg;

  localparam int CFU_DATA_W = 32;
  localparam int CFU_FN_W   = 10;

  // Function ids understood by the SIMD MAC CFU (10-bit id space).
  localparam logic [CFU_FN_W-1:0] FN_ACC8    = 10'd0;
  localparam logic [CFU_FN_W-1:0] FN_LOAD_HI = 10'd1;
  localparam logic [CFU_FN_W-1:0] FN_SET_OFS = 10'd2;
  localparam logic [CFU_FN_W-1:0] FN_ACC4    = 10'd3;

  typedef enum logic [2:0] {
    IDLE,
    SET_OFS,
    WAIT_OFS,
    FETCH,
    ISSUE,
    WAIT_RSP,
    DONE
  } issuer_state_e;

  // States in which the issuer is waiting on the CFU and the watchdog runs.
  function automatic logic is_cfu_wait(input issuer_state_e s);
    return (s == SET_OFS) || (s == WAIT_OFS) || (s == ISSUE) || (s == WAIT_RSP);
  endfunction

endpackage

// File: rtl/cfu_cmd_issuer.sv
// Hardware initiator for the SIMD MAC CFU. Runs one dot-product job:
// SET_OFS with the input offset, then one ACC4 per operand word pair pulled
// from the operand stream; the last CFU response is returned as the result.
// At most one CFU command is outstanding. A watchdog aborts the job if the CFU
// stops accepting commands or stops responding.
module cfu_cmd_issuer
  import cfu_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // job request
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [LEN_W-1:0]      job_len,
  input  logic [15:0]           job_offset,
  // operand stream
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [CFU_DATA_W-1:0] op_data_0,
  input  logic [CFU_DATA_W-1:0] op_data_1,
  // CFU command channel
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CFU_FN_W-1:0]   cmd_payload_function_id,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_0,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_1,
  // CFU response channel
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [CFU_DATA_W-1:0] rsp_payload_outputs_0,
  // result
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CFU_DATA_W-1:0] res_data,
  output logic                  res_err,
  output logic                  busy
);

  // Watchdog counts 0 .. RSP_TIMEOUT-1 within one state.
  localparam int unsigned TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  issuer_state_e         state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      cnt_inc;
  logic [CFU_FN_W-1:0]   fn_q, fn_d;
  logic [CFU_DATA_W-1:0] in0_q, in0_d;
  logic [CFU_DATA_W-1:0] in1_q, in1_d;
  logic [CFU_DATA_W-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tmo_hit;

  assign cnt_inc = cnt_q + LEN_W'(1);
  assign tmo_hit = (RSP_TIMEOUT != 0) && (tmo_q == TMO_W'(RSP_TIMEOUT - 1));

  // Next-state, payload capture, result capture and watchdog update.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fn_d       = fn_q;
    in0_d      = in0_q;
    in1_d      = in1_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          len_d   = job_len;
          cnt_d   = '0;
          fn_d    = FN_SET_OFS;
          in0_d   = {16'h0, job_offset};
          in1_d   = '0;
          state_d = SET_OFS;
        end
      end
      SET_OFS: begin
        if (cmd_ready) begin
          state_d = WAIT_OFS;
        end else if (tmo_hit) begin
          res_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      WAIT_OFS: begin
        if (rsp_valid) begin
          res_data_d = rsp_payload_outputs_0;
          state_d    = (len_q == '0) ? DONE : FETCH;
        end else if (tmo_hit) begin
          res_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      FETCH: begin
        if (op_valid) begin
          fn_d    = FN_ACC4;
          in0_d   = op_data_0;
          in1_d   = op_data_1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = WAIT_RSP;
        end else if (tmo_hit) begin
          res_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          res_data_d = rsp_payload_outputs_0;
          cnt_d      = cnt_inc;
          state_d    = (cnt_inc == len_q) ? DONE : FETCH;
        end else if (tmo_hit) begin
          res_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog restarts on every state change and only runs while the
    // issuer is waiting on the CFU.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((RSP_TIMEOUT != 0) && is_cfu_wait(state_q)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous and clears all of it.
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      fn_q       <= '0;
      in0_q      <= '0;
      in1_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      fn_q       <= fn_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Handshake outputs are pure state decodes; payload comes straight from
  // registers that only change in IDLE and FETCH, so it is stable while
  // cmd_valid waits for cmd_ready.
  assign job_ready               = (state_q == IDLE);
  assign op_ready                = (state_q == FETCH);
  assign cmd_valid               = (state_q == SET_OFS) || (state_q == ISSUE);
  assign rsp_ready               = (state_q == WAIT_OFS) || (state_q == WAIT_RSP);
  assign res_valid               = (state_q == DONE);
  assign busy                    = (state_q != IDLE);
  assign cmd_payload_function_id = fn_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign res_data                = res_data_q;
  assign res_err                 = res_err_q;

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Self-checking bench for cfu_cmd_issuer. A behavioural SIMD MAC CFU answers
// the command channel; expected commands and results are derived from the
// job descriptions with plain arithmetic and compared every cycle.
module tb_cfu_cmd_issuer;
  import cfu_pkg::*;

  localparam int LEN_W = 16;
  localparam int TMO   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              job_valid, job_ready;
  logic [LEN_W-1:0]  job_len;
  logic [15:0]       job_offset;
  logic              op_valid, op_ready;
  logic [31:0]       op_data_0, op_data_1;
  logic              cmd_valid, cmd_ready;
  logic [9:0]        cmd_payload_function_id;
  logic [31:0]       cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_payload_outputs_0;
  logic              res_valid, res_ready;
  logic [31:0]       res_data;
  logic              res_err;
  logic              busy;

  cfu_cmd_issuer #(.LEN_W(LEN_W), .RSP_TIMEOUT(TMO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .job_valid               (job_valid),
    .job_ready               (job_ready),
    .job_len                 (job_len),
    .job_offset              (job_offset),
    .op_valid                (op_valid),
    .op_ready                (op_ready),
    .op_data_0               (op_data_0),
    .op_data_1               (op_data_1),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_err                 (res_err),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } res_t;

  int checks = 0;
  int errors = 0;

  // Expectations derived from the job list.
  cmd_t        exp_cmd_q[$];
  res_t        exp_res_q[$];
  logic [31:0] op0_q[$];
  logic [31:0] op1_q[$];

  // Environment controls set by the main sequence.
  bit stall_en  = 1'b0;
  bit mute_acc  = 1'b0;
  int res_hold  = 0;

  // Environment / CFU model state, owned by the per-cycle process.
  bit                 job_active = 1'b0;
  bit                 outstanding = 1'b0;
  bit                 rsp_pending = 1'b0;
  int                 rsp_delay = 0;
  logic [31:0]        rsp_val = '0;
  logic signed [31:0] cfu_acc = '0;
  logic signed [31:0] cfu_ofs = '0;
  bit                 prev_stall = 1'b0;
  cmd_t               prev_cmd, cur_cmd;
  int                 cmd_stalls = 0;
  int                 op_stalls = 0;

  // Per-job observations.
  int          jobs_taken = 0;
  int          jobs_done = 0;
  int          job_acc_cnt = 0;
  int          job_op_ready_cyc = 0;
  int          job_acc_wait_cyc = 0;
  int          job_res_valid_cyc = 0;
  logic [31:0] last_res_data = '0;
  logic        last_res_err = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no progress within cycle bound at %0t", name, $time);
  endtask

  // Four signed int8 lanes: (input + offset) * filter, summed.
  function automatic logic [31:0] dot4(input logic signed [31:0] ofs,
                                       input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    logic signed [7:0]  xa, xb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      xa = a[8*k +: 8];
      xb = b[8*k +: 8];
      s += (32'(xa) + ofs) * 32'(xb);
    end
    return s;
  endfunction

  // Per-cycle environment: compare outputs, then drive CFU, operand source
  // and result sink for the next edge.
  initial begin : cycle_proc
    forever begin
      @(negedge clk);
      if (reset) begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
        op_valid = 1'b0; op_data_0 = '0; op_data_1 = '0; res_ready = 1'b0;
        exp_cmd_q.delete(); exp_res_q.delete(); op0_q.delete(); op1_q.delete();
        job_active = 1'b0; outstanding = 1'b0; rsp_pending = 1'b0;
        prev_stall = 1'b0; cfu_acc = '0; cfu_ofs = '0; cmd_stalls = 0; op_stalls = 0;
      end else begin
        // ---- compare ----
        check("busy", busy, job_active);
        check("job_ready", job_ready, !job_active);
        cur_cmd = '{fn: cmd_payload_function_id, in0: cmd_payload_inputs_0,
                    in1: cmd_payload_inputs_1};
        if (cmd_valid) begin
          check("cmd_while_outstanding", outstanding, 1'b0);
          if (exp_cmd_q.size() == 0) begin
            fail_bound("unexpected_cmd");
          end else begin
            check("cmd_fn", cur_cmd.fn, exp_cmd_q[0].fn);
            check("cmd_in0", cur_cmd.in0, exp_cmd_q[0].in0);
            check("cmd_in1", cur_cmd.in1, exp_cmd_q[0].in1);
          end
          if (prev_stall) check("cmd_stable", cur_cmd, prev_cmd);
        end
        if (op_ready) begin
          job_op_ready_cyc++;
          check("op_ready_needed", op0_q.size() > 0, 1'b1);
          check("op_ready_outstanding", outstanding, 1'b0);
        end
        if (rsp_ready) begin
          check("rsp_ready_outstanding", outstanding, 1'b1);
          if (job_acc_cnt > 0) job_acc_wait_cyc++;
        end
        if (res_valid) begin
          job_res_valid_cyc++;
          if (exp_res_q.size() == 0) begin
            fail_bound("unexpected_res");
          end else begin
            check("res_data", res_data, exp_res_q[0].data);
            check("res_err", res_err, exp_res_q[0].err);
          end
        end

        // ---- CFU response channel ----
        rsp_valid = 1'b0;
        rsp_payload_outputs_0 = $urandom();
        if (rsp_pending) begin
          if (rsp_delay > 0) begin
            rsp_delay--;
          end else begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = rsp_val;
          end
        end
        if (rsp_valid && rsp_ready) begin
          rsp_pending = 1'b0;
          outstanding = 1'b0;
        end

        // ---- CFU command channel ----
        if (!stall_en || cmd_stalls >= 3) cmd_ready = 1'b1;
        else cmd_ready = ($urandom_range(0, 1) == 1);
        cmd_stalls = (cmd_valid && !cmd_ready) ? cmd_stalls + 1 : 0;
        prev_stall = cmd_valid && !cmd_ready;
        prev_cmd   = cur_cmd;
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd_q.size() > 0) void'(exp_cmd_q.pop_front());
          outstanding = 1'b1;
          if (cur_cmd.fn == FN_SET_OFS) begin
            cfu_ofs = {{16{cur_cmd.in0[15]}}, cur_cmd.in0[15:0]};
            cfu_acc = '0;
            rsp_val = '0;
          end else begin
            cfu_acc = cfu_acc + dot4(cfu_ofs, cur_cmd.in0, cur_cmd.in1);
            rsp_val = cfu_acc;
            job_acc_cnt++;
          end
          rsp_pending = !(mute_acc && cur_cmd.fn == FN_ACC4);
          rsp_delay   = stall_en ? int'($urandom_range(0, 3)) : 0;
        end

        // ---- operand stream (offered whenever data exists) ----
        if (op0_q.size() > 0 && (!stall_en || op_stalls >= 3 || $urandom_range(0, 1) == 1)) begin
          op_valid = 1'b1; op_data_0 = op0_q[0]; op_data_1 = op1_q[0];
        end else begin
          op_valid = 1'b0; op_data_0 = $urandom(); op_data_1 = $urandom();
        end
        op_stalls = (op_ready && !op_valid) ? op_stalls + 1 : 0;
        if (op_valid && op_ready) begin
          void'(op0_q.pop_front());
          void'(op1_q.pop_front());
        end

        // ---- result sink ----
        if (res_valid && res_hold > 0) begin
          res_ready = 1'b0;
          res_hold--;
        end else begin
          res_ready = 1'b1;
        end
        if (res_valid && res_ready) begin
          last_res_data = res_data;
          last_res_err  = res_err;
          if (exp_res_q.size() > 0) void'(exp_res_q.pop_front());
          job_active = 1'b0;
          jobs_done++;
        end

        // ---- job acceptance ----
        if (job_valid && job_ready) begin
          job_active        = 1'b1;
          jobs_taken++;
          job_acc_cnt       = 0;
          job_op_ready_cyc  = 0;
          job_acc_wait_cyc  = 0;
          job_res_valid_cyc = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, job_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_op_ready"}, op_ready, 1'b0);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_rsp_ready"}, rsp_ready, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_err"}, res_err, 1'b0);
    check({tag, "_res_data"}, res_data, 32'h0);
    check({tag, "_payload"}, {cmd_payload_function_id, cmd_payload_inputs_0,
                              cmd_payload_inputs_1}, 74'h0);
  endtask

  // Called at posedge+2; leaves the caller at posedge+2.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  // Builds the expected command/result stream for a job and requests it.
  task automatic start_job(input int len, input logic [15:0] ofs,
                           input logic [31:0] a, input logic [31:0] b, input bit err);
    logic [31:0] acc;
    int          taken;
    acc = '0;
    exp_cmd_q.push_back('{fn: FN_SET_OFS, in0: {16'h0, ofs}, in1: 32'h0});
    for (int i = 0; i < len; i++) begin
      exp_cmd_q.push_back('{fn: FN_ACC4, in0: a, in1: b});
      op0_q.push_back(a);
      op1_q.push_back(b);
      acc = acc + dot4({{16{ofs[15]}}, ofs}, a, b);
    end
    // An abort on the first word leaves the SET_OFS response (0) captured.
    exp_res_q.push_back('{data: err ? 32'h0 : acc, err: err});
    taken      = jobs_taken;
    job_len    = len[LEN_W-1:0];
    job_offset = ofs;
    job_valid  = 1'b1;
    for (int c = 0; c < 50 && jobs_taken == taken; c++) begin
      @(posedge clk);
      #2;
    end
    job_valid = 1'b0;
    if (jobs_taken == taken) fail_bound("job_accept");
  endtask

  task automatic wait_done(input string name);
    int d;
    d = jobs_done;
    for (int c = 0; c < 400 && jobs_done == d; c++) begin
      @(posedge clk);
      #2;
    end
    if (jobs_done == d) fail_bound(name);
  endtask

  initial begin : main
    reset = 1'b1; job_valid = 1'b0; job_len = '0; job_offset = '0;
    op_valid = 1'b0; op_data_0 = '0; op_data_1 = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0; res_ready = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Single word: (129+130+131+132)*1 = 522.
    start_job(1, 16'd128, 32'h01020304, 32'h01010101, 1'b0);
    wait_done("single_done");
    check("single_res", last_res_data, 32'd522);
    check("single_err", last_res_err, 1'b0);
    check("single_acc_cmds", job_acc_cnt, 1);

    // Three words with stalls everywhere: 3 * 4 * (2*3) = 72.
    stall_en = 1'b1;
    res_hold = 5;
    start_job(3, 16'd0, 32'h02020202, 32'h03030303, 1'b0);
    wait_done("multi_done");
    stall_en = 1'b0;
    check("multi_res", last_res_data, 32'd72);
    check("multi_acc_cmds", job_acc_cnt, 3);
    check("multi_res_valid_hold", job_res_valid_cyc, 6);

    // Zero length: only SET_OFS, no operand fetch, CFU returns 0.
    start_job(0, 16'd5, 32'h0, 32'h0, 1'b0);
    wait_done("zero_done");
    check("zero_res", last_res_data, 32'd0);
    check("zero_op_ready", job_op_ready_cyc, 0);
    check("zero_acc_cmds", job_acc_cnt, 0);

    // Signed: (-128 + -128) * -1 per lane = 1024.
    start_job(1, 16'hFF80, 32'h80808080, 32'hFFFFFFFF, 1'b0);
    wait_done("signed_done");
    check("signed_res", last_res_data, 32'd1024);

    // Timeout: ACC4 accepted but never answered.
    mute_acc = 1'b1;
    start_job(1, 16'd0, 32'h01010101, 32'h01010101, 1'b1);
    wait_done("timeout_done");
    mute_acc = 1'b0;
    check("timeout_err", last_res_err, 1'b1);
    check("timeout_wait_cycles", job_acc_wait_cyc, TMO);
    check("timeout_res_data", last_res_data, 32'd0);
    check("timeout_job_ready", job_ready, 1'b1);
    do_reset();

    // Reset during WAIT_RSP of word 2 of 4.
    start_job(4, 16'd0, 32'h11223344, 32'h01020304, 1'b0);
    for (int c = 0; c < 100 && !(rsp_ready && job_acc_cnt == 2); c++) begin
      @(posedge clk);
      #2;
    end
    if (!(rsp_ready && job_acc_cnt == 2)) fail_bound("mid_job_wait_rsp");
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("midreset");
    reset = 1'b0;

    // Fresh job after the abort: 127 * 4 = 508.
    start_job(1, 16'd0, 32'h7F7F7F7F, 32'h01010101, 1'b0);
    wait_done("post_reset_done");
    check("post_reset_res", last_res_data, 32'd508);
    check("post_reset_err", last_res_err, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
